ft232hq_send: RTL and testbench

- FT232H synchronous-FIFO (245 sync) transmit driver: the FPGA→host direction of the USB link.
- Pulls bytes from a show-ahead (first-word-fall-through) transmit FIFO and writes them to the FT232H under TXE#/WR# handshake.
- Owns the shared 8-bit data bus only while the receive path is idle, and hands the bus back whenever the host has data pending.
- Sits beside the receive driver at the USB top level; the top level builds the bidirectional pad from `data_send`/`data_oe`.

---
 rtl/usb_pkg.sv | 14 +
 rtl/ft232hq_send.sv | 91 +++++++++
 tb/tb_ft232hq_send.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB-side definitions: transmit FSM encoding and default burst length,
// used by the FT232H transmit driver and the USB top level.
package usb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_SEND    = 2'd2,
    ST_RELEASE = 2'd3
  } tx_state_t;

  localparam int unsigned MAX_BURST_DEFAULT = 512;

endpackage

// File: rtl/ft232hq_send.sv
// FT232H 245-sync transmit driver: moves bytes from a show-ahead FIFO to the
// chip under TXE#/WR#, owning the shared data bus only while the receiver is idle.
module ft232hq_send
  import usb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             txe_n,
  input  logic             rxf_n,
  input  logic             rx_oe_n,
  output logic             wr_n,
  output logic [7:0]       data_send,
  output logic             data_oe,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data_out,
  output logic             fifo_rd_en,
  output logic             tx_busy,
  output logic [CNT_W-1:0] tx_count
);

  localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);

  tx_state_t   state, next_state;
  logic [7:0]  hold;
  logic        hv, hv_next;
  logic [15:0] burst_cnt;
  logic        accept, load, burst_done, bus_free;

  assign bus_free   = rxf_n && rx_oe_n;
  assign accept     = (state == ST_SEND) && !wr_n && !txe_n;
  assign burst_done = accept && (burst_cnt == BURST_LAST);
  assign data_send  = hold;
  assign tx_busy    = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking with defaults.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (bus_free && (hv || !fifo_empty)) next_state = ST_ARB;
      ST_ARB:     next_state = ST_SEND;
      ST_SEND:    if (!rxf_n || burst_done || !hv_next) next_state = ST_RELEASE;
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // A FIFO pop happens exactly when its byte lands in hold.
  always_comb begin
    load = 1'b0;
    unique case (state)
      ST_IDLE: load = bus_free && !hv && !fifo_empty;
      ST_SEND: load = accept && !fifo_empty;
      default: load = 1'b0;
    endcase
    hv_next = load || (hv && !accept);
    // NOTE: the pop is gated by reset so the FIFO is never drained while the
    // async-reset state is still being held.
    fifo_rd_en = load && !rst;
  end

  // Pad controls are registered from the next state so WR# and the FSM never
  // disagree about which edge can accept a byte.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hold      <= 8'h00;
      hv        <= 1'b0;
      wr_n      <= 1'b1;
      data_oe   <= 1'b0;
      tx_count  <= '0;
      burst_cnt <= '0;
    end else begin
      if (load) hold <= fifo_data_out;
      hv      <= hv_next;
      wr_n    <= !((next_state == ST_SEND) && hv_next);
      data_oe <= (next_state != ST_IDLE);
      if (accept) tx_count <= tx_count + CNT_W'(1);
      if (state == ST_ARB)  burst_cnt <= '0;
      else if (accept)      burst_cnt <= burst_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ft232hq_send.sv
// Self-checking bench for ft232hq_send: vector table, directed corner cases,
// randomized traffic against an in-order byte scoreboard.
module tb_ft232hq_send;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst = 1'b1, txe_n = 1'b1, rxf_n = 1'b1, rx_oe_n = 1'b1;

  // DUT A: default burst / 32-bit counter
  logic        wr_n_a, data_oe_a, fifo_empty_a, rd_en_a, tx_busy_a;
  logic [7:0]  data_send_a, fifo_dout_a;
  logic [31:0] tx_count_a;
  // DUT B: short burst / 4-bit counter
  logic        wr_n_b, data_oe_b, fifo_empty_b, rd_en_b, tx_busy_b;
  logic [7:0]  data_send_b, fifo_dout_b;
  logic [3:0]  tx_count_b;

  ft232hq_send dut_a (
    .clock(clock), .rst(rst), .txe_n(txe_n), .rxf_n(rxf_n), .rx_oe_n(rx_oe_n),
    .wr_n(wr_n_a), .data_send(data_send_a), .data_oe(data_oe_a),
    .fifo_empty(fifo_empty_a), .fifo_data_out(fifo_dout_a), .fifo_rd_en(rd_en_a),
    .tx_busy(tx_busy_a), .tx_count(tx_count_a)
  );

  ft232hq_send #(.MAX_BURST(4), .CNT_W(4)) dut_b (
    .clock(clock), .rst(rst), .txe_n(txe_n), .rxf_n(rxf_n), .rx_oe_n(rx_oe_n),
    .wr_n(wr_n_b), .data_send(data_send_b), .data_oe(data_oe_b),
    .fifo_empty(fifo_empty_b), .fifo_data_out(fifo_dout_b), .fifo_rd_en(rd_en_b),
    .tx_busy(tx_busy_b), .tx_count(tx_count_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Show-ahead FIFO models; pointers advance on the DUT pop.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] wp_a = 8'd0, rp_a = 8'd0, wp_b = 8'd0, rp_b = 8'd0;
  assign fifo_empty_a = (wp_a == rp_a);
  assign fifo_dout_a  = mem_a[rp_a];
  assign fifo_empty_b = (wp_b == rp_b);
  assign fifo_dout_b  = mem_b[rp_b];

  always @(posedge clock) begin
    if (rd_en_a) begin
      if (fifo_empty_a) check("a_pop_when_empty", 1, 0);
      rp_a <= rp_a + 8'd1;
    end
    if (rd_en_b) begin
      if (fifo_empty_b) check("b_pop_when_empty", 1, 0);
      rp_b <= rp_b + 8'd1;
    end
  end

  // Reference: bytes must reach the chip in push order, each exactly once.
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int acc_a = 0, acc_b = 0;

  always @(negedge clock) begin
    if (!rst && !wr_n_a && !txe_n) begin
      acc_a++;
      check("a_oe_during_wr", data_oe_a, 1);
      if (exp_a.size() == 0) check("a_extra_byte", 1, 0);
      else                   check("a_byte", data_send_a, exp_a.pop_front());
    end
    if (!rst && !wr_n_b && !txe_n) begin
      acc_b++;
      if (exp_b.size() == 0) check("b_extra_byte", 1, 0);
      else                   check("b_byte", data_send_b, exp_b.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_a(input logic [7:0] b);
    mem_a[wp_a] = b;
    wp_a = wp_a + 8'd1;
    exp_a.push_back(b);
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wp_b] = b;
    wp_b = wp_b + 8'd1;
    exp_b.push_back(b);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || tx_busy_a || tx_busy_b) && n < budget) begin
      tick();
      n++;
    end
    check(name, n < budget, 1);
  endtask

  typedef struct {
    logic        txe_n;
    logic        rxf_n;
    logic        wr_n;
    logic        oe;
    logic [7:0]  data;
    logic        busy;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int runs[$];
    int gaps[$];
    logic acc_bits[64];

    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 32'd0};  // IDLE -> ARB, A1 loaded
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 32'd0};  // ARB -> SEND
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 32'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 32'd2};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b1, 32'd3};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA4, 1'b1, 32'd4};  // last byte, RELEASE
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA4, 1'b0, 32'd4};  // IDLE, bus released
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA4, 1'b0, 32'd4};

    // Reset state, with data already waiting: no pop while reset is held.
    tick(); tick();
    for (int i = 0; i < 4; i++) push_a(8'hA1 + 8'(i));
    #1;
    check("rst_rd_en", rd_en_a, 0);
    check("rst_wr_n", wr_n_a, 1);
    check("rst_data_oe", data_oe_a, 0);
    check("rst_data_send", data_send_a, 0);
    check("rst_tx_busy", tx_busy_a, 0);
    check("rst_tx_count", tx_count_a, 0);
    txe_n = 1'b0;
    rst   = 1'b0;

    // Four-byte burst, cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      txe_n = vecs[i].txe_n;
      rxf_n = vecs[i].rxf_n;
      tick();
      check($sformatf("vec%0d_wr_n", i), wr_n_a, vecs[i].wr_n);
      check($sformatf("vec%0d_data_oe", i), data_oe_a, vecs[i].oe);
      check($sformatf("vec%0d_data_send", i), data_send_a, vecs[i].data);
      check($sformatf("vec%0d_tx_busy", i), tx_busy_a, vecs[i].busy);
      check($sformatf("vec%0d_tx_count", i), tx_count_a, vecs[i].cnt);
    end

    // TXE# stall: 8'h55 held on the bus, then accepted once.
    txe_n = 1'b1;
    push_a(8'h55);
    tick(); tick();
    check("stall_wr_low", wr_n_a, 0);
    check("stall_data", data_send_a, 8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_wr_n", i), wr_n_a, 0);
      check($sformatf("stall%0d_data", i), data_send_a, 8'h55);
      check($sformatf("stall%0d_oe", i), data_oe_a, 1);
      check($sformatf("stall%0d_cnt", i), tx_count_a, 4);
    end
    txe_n = 1'b0;
    tick();
    check("stall_accept_cnt", tx_count_a, 5);
    check("stall_after_wr_n", wr_n_a, 1);
    tick(); tick();
    check("stall_once_cnt", tx_count_a, 5);
    check("stall_idle", tx_busy_a, 0);

    // RXF# priority mid-burst after 10 accepted bytes.
    for (int i = 0; i < 20; i++) push_a(8'h10 + 8'(i));
    n = 0;
    while (tx_count_a != 32'd15 && n < 40) begin tick(); n++; end
    check("rxf_wait10", n < 40, 1);
    rxf_n = 1'b0;
    tick();
    check("rxf_wr_n_next", wr_n_a, 1);
    check("rxf_same_cycle_accept", tx_count_a, 16);
    tick();
    check("rxf_oe_off", data_oe_a, 0);
    check("rxf_idle", tx_busy_a, 0);
    check("rxf_retained", data_send_a, 8'h1B);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rxf_hold%0d_wr_n", i), wr_n_a, 1);
      check($sformatf("rxf_hold%0d_oe", i), data_oe_a, 0);
    end
    rxf_n = 1'b1;
    n = 0;
    while (wr_n_a && n < 10) begin tick(); n++; end
    check("rxf_resume", n < 10, 1);
    check("rxf_first_after", data_send_a, 8'h1B);
    drain("rxf_drain", 100);
    check("rxf_total", tx_count_a, 25);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      if (exp_a.size() < 200 && $urandom_range(0, 1) == 1) push_a(8'($urandom));
      txe_n   = ($urandom_range(0, 3) == 0);
      rxf_n   = ($urandom_range(0, 7) != 0);
      rx_oe_n = ($urandom_range(0, 7) != 0);
      tick();
    end
    txe_n = 1'b0; rxf_n = 1'b1; rx_oe_n = 1'b1;
    drain("rand_drain", 2000);
    check("rand_remaining", exp_a.size(), 0);
    check("rand_tx_count", tx_count_a, acc_a);

    // Reset in the middle of a burst.
    for (int i = 0; i < 10; i++) push_a(8'hC0 + 8'(i));
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy_before", tx_busy_a, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_n", wr_n_a, 1);
    check("mid_rst_oe", data_oe_a, 0);
    check("mid_rst_data", data_send_a, 0);
    check("mid_rst_busy", tx_busy_a, 0);
    check("mid_rst_cnt", tx_count_a, 0);
    check("mid_rst_rd_en", rd_en_a, 0);
    wp_a = rp_a;
    exp_a.delete();
    acc_a = 0;
    acc_b = 0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post_rst%0d_wr_n", i), wr_n_a, 1);
      check($sformatf("post_rst%0d_busy", i), tx_busy_a, 0);
    end
    push_a(8'hD0);
    push_a(8'hD1);
    drain("post_rst_drain", 50);
    check("post_rst_cnt", tx_count_a, 2);

    // Burst limit of 4 on DUT B: 9 bytes group as 4/4/1.
    for (int i = 0; i < 9; i++) push_b(8'h30 + 8'(i));
    for (int i = 0; i < 64; i++) begin
      tick();
      acc_bits[i] = !wr_n_b && !txe_n;
    end
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (acc_bits[i]) n++;
      if ((!acc_bits[i] || i == 63) && n != 0) begin
        runs.push_back(n);
        n = 0;
      end
    end
    n = -1;
    for (int i = 0; i < 64; i++) begin
      if (acc_bits[i]) begin
        if (n > 0) gaps.push_back(n);
        n = 0;
      end else if (n >= 0) n++;
    end
    check("burst_groups", runs.size(), 3);
    if (runs.size() == 3) begin
      check("burst_g0", runs[0], 4);
      check("burst_g1", runs[1], 4);
      check("burst_g2", runs[2], 1);
    end
    check("burst_gap_count", gaps.size(), 2);
    if (gaps.size() == 2) begin
      check("burst_gap0", gaps[0], 3);
      check("burst_gap1", gaps[1], 3);
    end
    check("burst_cnt9", tx_count_b, 9);

    // 4-bit counter wraps: 17 bytes in total reads 1.
    for (int i = 0; i < 8; i++) push_b(8'h40 + 8'(i));
    drain("wrap_drain", 100);
    check("wrap_model_count", acc_b, 17);
    check("wrap_cnt", tx_count_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
